// File: rtl/cpu_pkg.sv
// Shared core definitions used by rename, ROB and issue: widths, entry layout, constants.
package cpu_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int NUM_PREG  = 64;
  localparam int CMP_W     = 3;
  localparam int RET_W     = 2;

  localparam logic [PREG_W-1:0] PREG_ZERO = '0;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] dr_p;
    logic [PREG_W-1:0] old_dr;
    logic [31:0]       value;
  } rob_entry_t;
endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire chain: walks RET_W entries from head, stopping at the first not-ready entry.
module rob_retire_sel #(
  parameter int DEPTH  = cpu_pkg::ROB_DEPTH,
  parameter int TAG_W  = cpu_pkg::TAG_W,
  parameter int RET_W  = cpu_pkg::RET_W,
  parameter int NRET_W = $clog2(RET_W + 1)
) (
  input  logic [TAG_W-1:0]            head_idx,
  input  logic [DEPTH-1:0]            entry_ready,
  output logic [NRET_W-1:0]           nret,
  output logic [RET_W-1:0]            slot_vld,
  output logic [RET_W-1:0][TAG_W-1:0] slot_idx
);

  always_comb begin
    logic chain;
    chain    = 1'b1;
    nret     = '0;
    slot_vld = '0;
    slot_idx = '0;
    for (int k = 0; k < RET_W; k++) begin
      slot_idx[k] = head_idx + TAG_W'(k);
      slot_vld[k] = chain && entry_ready[slot_idx[k]];
      chain       = slot_vld[k];
      nret        = nret + NRET_W'(slot_vld[k]);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates tags from rename, collects completions, retires in program order
// and pulses the old-preg free vector back to rename.
module reorder_buffer #(
  parameter int DEPTH  = cpu_pkg::ROB_DEPTH,
  parameter int TAG_W  = cpu_pkg::TAG_W,
  parameter int PREG_W = cpu_pkg::PREG_W,
  parameter int AREG_W = cpu_pkg::AREG_W,
  parameter int CMP_W  = cpu_pkg::CMP_W,
  parameter int RET_W  = cpu_pkg::RET_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic                         alloc_has_dest,
  input  logic [AREG_W-1:0]            alloc_areg,
  input  logic [PREG_W-1:0]            alloc_dr_p,
  input  logic [PREG_W-1:0]            alloc_old_dr,
  output logic                         alloc_ready,
  output logic [TAG_W-1:0]             alloc_tag,
  input  logic [CMP_W-1:0]             cmp_valid,
  input  logic [CMP_W*TAG_W-1:0]       cmp_tag,
  input  logic [CMP_W*32-1:0]          cmp_value,
  output logic [RET_W-1:0]             ret_valid,
  output logic [RET_W*AREG_W-1:0]      ret_areg,
  output logic [RET_W*PREG_W-1:0]      ret_preg,
  output logic [RET_W*32-1:0]          ret_value,
  output logic [cpu_pkg::NUM_PREG-1:0] retire_free_vec,
  output logic                         rob_empty,
  output logic [TAG_W:0]               rob_count
);

  localparam int NRET_W = $clog2(RET_W + 1);

  cpu_pkg::rob_entry_t rob_q [DEPTH];
  logic [TAG_W:0]      head_q, tail_q, count_q;

  logic                            alloc_fire;
  logic [DEPTH-1:0]                entry_ready;
  logic [NRET_W-1:0]               nret;
  logic [RET_W-1:0]                slot_vld;
  logic [RET_W-1:0][TAG_W-1:0]     slot_idx;
  logic [DEPTH-1:0]                cmp_hit;
  logic [31:0]                     cmp_data [DEPTH];
  logic [DEPTH-1:0]                ret_clr;
  logic [RET_W*AREG_W-1:0]         areg_d;
  logic [RET_W*PREG_W-1:0]         preg_d;
  logic [RET_W*32-1:0]             value_d;
  logic [cpu_pkg::NUM_PREG-1:0]    free_d;

  // Allocation is gated on registered occupancy only; a same-cycle retire gives no credit.
  assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail_q[TAG_W-1:0];
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign rob_empty   = (count_q == '0);
  assign rob_count   = count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_ready[i] = rob_q[i].valid && rob_q[i].done;
  end

  rob_retire_sel #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .RET_W  (RET_W),
    .NRET_W (NRET_W)
  ) u_retire_sel (
    .head_idx    (head_q[TAG_W-1:0]),
    .entry_ready (entry_ready),
    .nret        (nret),
    .slot_vld    (slot_vld),
    .slot_idx    (slot_idx)
  );

  // Ports scanned high to low so the lowest-numbered port's value wins on a tag collision.
  always_comb begin
    logic [TAG_W-1:0] t;
    t       = '0;
    cmp_hit = '0;
    for (int i = 0; i < DEPTH; i++) cmp_data[i] = '0;
    for (int k = CMP_W - 1; k >= 0; k--) begin
      t = cmp_tag[k*TAG_W +: TAG_W];
      if (cmp_valid[k] && rob_q[t].valid) begin
        cmp_hit[t]  = 1'b1;
        cmp_data[t] = cmp_value[k*32 +: 32];
      end
    end
  end

  always_comb begin
    cpu_pkg::rob_entry_t e;
    e       = '0;
    ret_clr = '0;
    areg_d  = '0;
    preg_d  = '0;
    value_d = '0;
    free_d  = '0;
    for (int k = 0; k < RET_W; k++) begin
      e = rob_q[slot_idx[k]];
      if (slot_vld[k]) begin
        ret_clr[slot_idx[k]]    = 1'b1;
        value_d[k*32 +: 32]     = e.value;
        if (e.has_dest) begin
          areg_d[k*AREG_W +: AREG_W] = e.areg;
          preg_d[k*PREG_W +: PREG_W] = e.dr_p;
          if (e.old_dr != cpu_pkg::PREG_ZERO) free_d[e.old_dr] = 1'b1;
        end
      end
    end
  end

  // Entry storage: only valid/done are reset; payload fields are don't-care until allocated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i].valid <= 1'b0;
        rob_q[i].done  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cmp_hit[i]) begin
          rob_q[i].done  <= 1'b1;
          rob_q[i].value <= cmp_data[i];
        end
        if (ret_clr[i]) begin
          rob_q[i].valid <= 1'b0;
          rob_q[i].done  <= 1'b0;
        end
        if (alloc_fire && (tail_q[TAG_W-1:0] == TAG_W'(i))) begin
          rob_q[i].valid    <= 1'b1;
          rob_q[i].done     <= 1'b0;
          rob_q[i].has_dest <= alloc_has_dest;
          rob_q[i].areg     <= alloc_areg;
          rob_q[i].dr_p     <= alloc_dr_p;
          rob_q[i].old_dr   <= alloc_old_dr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + (TAG_W+1)'(nret);
      tail_q  <= tail_q + (TAG_W+1)'(alloc_fire);
      count_q <= count_q + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(nret);
    end
  end

  // Retire output stage: one-cycle pulses describing the entries retired at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_valid       <= '0;
      ret_areg        <= '0;
      ret_preg        <= '0;
      ret_value       <= '0;
      retire_free_vec <= '0;
    end else begin
      ret_valid       <= slot_vld;
      ret_areg        <= areg_d;
      ret_preg        <= preg_d;
      ret_value       <= value_d;
      retire_free_vec <= free_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: program-order scoreboard monitor plus table and directed sequences.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_has_dest;
  logic [4:0]  alloc_areg;
  logic [5:0]  alloc_dr_p, alloc_old_dr;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic [2:0]  cmp_valid;
  logic [11:0] cmp_tag;
  logic [95:0] cmp_value;
  logic [1:0]  ret_valid;
  logic [9:0]  ret_areg;
  logic [11:0] ret_preg;
  logic [63:0] ret_value;
  logic [63:0] retire_free_vec;
  logic        rob_empty;
  logic [4:0]  rob_count;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .alloc_valid     (alloc_valid),
    .alloc_has_dest  (alloc_has_dest),
    .alloc_areg      (alloc_areg),
    .alloc_dr_p      (alloc_dr_p),
    .alloc_old_dr    (alloc_old_dr),
    .alloc_ready     (alloc_ready),
    .alloc_tag       (alloc_tag),
    .cmp_valid       (cmp_valid),
    .cmp_tag         (cmp_tag),
    .cmp_value       (cmp_value),
    .ret_valid       (ret_valid),
    .ret_areg        (ret_areg),
    .ret_preg        (ret_preg),
    .ret_value       (ret_value),
    .retire_free_vec (retire_free_vec),
    .rob_empty       (rob_empty),
    .rob_count       (rob_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: allocations pushed in program order, popped when the DUT retires them.
  typedef struct {
    logic [3:0] tag;
    logic       hd;
    logic [4:0] areg;
    logic [5:0] drp;
    logic [5:0] old;
  } sb_t;

  sb_t         sbq[$];
  logic        mdone [16];
  logic [31:0] mval  [16];
  logic [4:0]  mtail;

  always @(posedge clk) begin : mon
    logic        s_rst, s_av, s_hd;
    logic [4:0]  s_areg;
    logic [5:0]  s_drp, s_old;
    logic [2:0]  s_cv;
    logic [11:0] s_ct;
    logic [95:0] s_cval;
    logic [63:0] efree;
    logic [1:0]  emask;
    logic [3:0]  t;
    logic        inq;
    int          n, pre;
    s_rst = rst;  s_av = alloc_valid; s_hd = alloc_has_dest; s_areg = alloc_areg;
    s_drp = alloc_dr_p; s_old = alloc_old_dr;
    s_cv = cmp_valid; s_ct = cmp_tag; s_cval = cmp_value;
    #1;
    if (s_rst) begin
      sbq.delete();
      mtail = '0;
      for (int i = 0; i < 16; i++) mdone[i] = 1'b0;
      chk("rst_ret_valid", ret_valid, 0);
      chk("rst_free_vec", retire_free_vec, 0);
      chk("rst_ret_value", ret_value, 0);
      chk("rst_rob_count", rob_count, 0);
      chk("rst_rob_empty", rob_empty, 1);
      chk("rst_alloc_ready", alloc_ready, 1);
      chk("rst_alloc_tag", alloc_tag, 0);
    end else begin
      pre = sbq.size();
      n   = 0;
      for (int k = 0; k < 2; k++)
        if (n == k && sbq.size() > k && mdone[sbq[k].tag]) n++;
      emask = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      chk("sb_ret_valid", ret_valid, emask);
      efree = '0;
      for (int k = 0; k < n; k++) begin
        chk("sb_ret_areg", ret_areg[k*5 +: 5], sbq[k].hd ? sbq[k].areg : 5'd0);
        chk("sb_ret_preg", ret_preg[k*6 +: 6], sbq[k].hd ? sbq[k].drp : 6'd0);
        chk("sb_ret_value", ret_value[k*32 +: 32], mval[sbq[k].tag]);
        if (sbq[k].hd && sbq[k].old != 6'd0) efree[sbq[k].old] = 1'b1;
      end
      chk("sb_free_vec", retire_free_vec, efree);
      for (int p = 2; p >= 0; p--) begin
        if (s_cv[p]) begin
          t   = s_ct[p*4 +: 4];
          inq = 1'b0;
          foreach (sbq[j]) if (sbq[j].tag == t) inq = 1'b1;
          if (inq) begin
            mdone[t] = 1'b1;
            mval[t]  = s_cval[p*32 +: 32];
          end
        end
      end
      for (int k = 0; k < n; k++) void'(sbq.pop_front());
      if (s_av && pre < 16) begin
        sbq.push_back('{mtail[3:0], s_hd, s_areg, s_drp, s_old});
        mdone[mtail[3:0]] = 1'b0;
        mtail++;
      end
      chk("sb_rob_count", rob_count, sbq.size());
      chk("sb_rob_empty", rob_empty, sbq.size() == 0);
      chk("sb_alloc_ready", alloc_ready, sbq.size() < 16);
      chk("sb_alloc_tag", alloc_tag, mtail[3:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    alloc_valid = 1'b0;
    cmp_valid   = '0;
  endtask

  task automatic alloc(input logic hd, input logic [4:0] a, input logic [5:0] d, input logic [5:0] o);
    alloc_valid    = 1'b1;
    alloc_has_dest = hd;
    alloc_areg     = a;
    alloc_dr_p     = d;
    alloc_old_dr   = o;
    tick();
  endtask

  task automatic cmp(input int p, input logic [3:0] t, input logic [31:0] v);
    cmp_valid[p]         = 1'b1;
    cmp_tag[p*4 +: 4]    = t;
    cmp_value[p*32 +: 32] = v;
  endtask

  typedef struct {
    logic        hd;
    logic [4:0]  areg;
    logic [5:0]  drp;
    logic [5:0]  old;
    logic [31:0] val;
    logic [4:0]  eareg;
    logic [5:0]  epreg;
    logic [63:0] efree;
  } vec_t;

  vec_t vt [4];

  initial begin
    vt[0] = '{1'b1, 5'd3,  6'd40, 6'd12, 32'h11111111, 5'd3,  6'd40, 64'h0000_0000_0000_1000};
    vt[1] = '{1'b0, 5'd7,  6'd20, 6'd0,  32'h22222222, 5'd0,  6'd0,  64'h0};
    vt[2] = '{1'b1, 5'd9,  6'd41, 6'd0,  32'h33333333, 5'd9,  6'd41, 64'h0};
    vt[3] = '{1'b1, 5'd31, 6'd63, 6'd63, 32'hDEADBEEF, 5'd31, 6'd63, 64'h8000_0000_0000_0000};

    rst = 1'b1;
    alloc_valid = 1'b0; alloc_has_dest = 1'b0; alloc_areg = '0; alloc_dr_p = '0; alloc_old_dr = '0;
    cmp_valid = '0; cmp_tag = '0; cmp_value = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_alloc_tag", alloc_tag, 0);
    chk("reset_rob_empty", rob_empty, 1);

    // Three allocations completing together: two retire, then the third.
    alloc(1'b1, 5'd1, 6'd32, 6'd5);
    alloc(1'b1, 5'd2, 6'd33, 6'd6);
    alloc(1'b1, 5'd3, 6'd34, 6'd7);
    cmp(0, 4'd0, 32'h100); cmp(1, 4'd1, 32'h101); cmp(2, 4'd2, 32'h102);
    tick();
    chk("t1_n1_no_retire", ret_valid, 2'b00);
    tick();
    chk("t1_n2_ret_valid", ret_valid, 2'b11);
    chk("t1_n2_free", retire_free_vec, 64'h60);
    chk("t1_n2_slot0_value", ret_value[31:0], 32'h100);
    chk("t1_n2_slot0_preg", ret_preg[5:0], 6'd32);
    tick();
    chk("t1_n3_ret_valid", ret_valid, 2'b01);
    chk("t1_n3_free", retire_free_vec, 64'h80);
    chk("t1_n3_empty", rob_empty, 1);

    // Younger completes first (two ports hit it, one port hits an idle tag).
    alloc(1'b1, 5'd4, 6'd35, 6'd8);
    alloc(1'b1, 5'd5, 6'd36, 6'd9);
    cmp(0, 4'd4, 32'hAAAA); cmp(2, 4'd4, 32'hBBBB); cmp(1, 4'd9, 32'h1234);
    tick();
    tick();
    tick();
    chk("t2_blocked", ret_valid, 2'b00);
    chk("t2_count", rob_count, 2);
    cmp(0, 4'd3, 32'h3333);
    tick();
    tick();
    chk("t2_ret_valid", ret_valid, 2'b11);
    chk("t2_slot0_preg", ret_preg[5:0], 6'd35);
    chk("t2_slot1_preg", ret_preg[11:6], 6'd36);
    chk("t2_slot1_value", ret_value[63:32], 32'hAAAA);
    chk("t2_free", retire_free_vec, 64'h300);
    tick();
    chk("t2_empty", rob_empty, 1);

    // Single-entry vectors covering dest, S-type and old_dr boundaries.
    for (int i = 0; i < 4; i++) begin
      alloc(vt[i].hd, vt[i].areg, vt[i].drp, vt[i].old);
      cmp(0, 4'(5 + i), vt[i].val);
      tick();
      tick();
      chk("vec_ret_valid", ret_valid, 2'b01);
      chk("vec_ret_areg", ret_areg[4:0], vt[i].eareg);
      chk("vec_ret_preg", ret_preg[5:0], vt[i].epreg);
      chk("vec_ret_value", ret_value[31:0], vt[i].val);
      chk("vec_free", retire_free_vec, vt[i].efree);
    end

    // Reset with eight entries in flight, head ones already done.
    for (int i = 0; i < 8; i++) alloc(1'b1, 5'(i + 1), 6'(40 + i), 6'(10 + i));
    cmp(0, 4'd9, 32'h9); cmp(1, 4'd10, 32'hA); cmp(2, 4'd11, 32'hB);
    tick();
    cmp(0, 4'd12, 32'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ret_valid", ret_valid, 2'b00);
    chk("mrst_count", rob_count, 0);
    tick();
    chk("mrst_next_ret_valid", ret_valid, 2'b00);
    chk("mrst_next_free", retire_free_vec, 0);
    chk("mrst_next_alloc_tag", alloc_tag, 0);

    // Fill, drop the overflow, retire one, allocate into the wrapped slot, drain.
    for (int i = 0; i < 16; i++) alloc(1'b1, 5'(i), 6'(16 + i), 6'(20 + i));
    chk("fill_ready", alloc_ready, 0);
    chk("fill_count", rob_count, 16);
    alloc(1'b1, 5'd30, 6'd50, 6'd51);
    chk("fill_drop_count", rob_count, 16);
    chk("fill_drop_tag", alloc_tag, 0);
    cmp(0, 4'd0, 32'h5000);
    tick();
    tick();
    chk("fill_ret_one", ret_valid, 2'b01);
    chk("fill_ready_again", alloc_ready, 1);
    chk("fill_wrap_tag", alloc_tag, 0);
    alloc(1'b1, 5'd17, 6'd60, 6'd61);
    chk("wrap_count", rob_count, 16);
    for (int t = 1; t < 16; t++) begin
      cmp(0, 4'(t), 32'(t * 16));
      tick();
    end
    cmp(0, 4'd0, 32'hF00D);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (rob_empty) break;
      tick();
    end
    chk("drain_empty", rob_empty, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
